// File: rtl/irq_service_arbiter_if.sv
// rtl/irq_service_arbiter_if.sv - source/CPU signal bundle for irq_service_arbiter
interface irq_service_arbiter_if #(
    parameter int NUM_IRQ = 3,
    parameter int ID_W    = $clog2(NUM_IRQ)
);
    logic [NUM_IRQ-1:0] irq_req;
    logic [NUM_IRQ-1:0] irq_enable;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               rr_mode;
    logic               cpu_ack;
    logic               cpu_eoi;
    logic               irq_out;
    logic [ID_W-1:0]    irq_id;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending;
    logic               timeout_err;

    modport master (
        output irq_req, irq_enable, irq_mask, rr_mode, cpu_ack, cpu_eoi,
        input  irq_out, irq_id, in_service, pending, timeout_err
    );

    modport slave (
        input  irq_req, irq_enable, irq_mask, rr_mode, cpu_ack, cpu_eoi,
        output irq_out, irq_id, in_service, pending, timeout_err
    );
endinterface

// File: rtl/irq_service_arbiter.sv
// rtl/irq_service_arbiter.sv - interrupt pending/arbitration/ack-eoi sequencer
// Optional ack timeout withdrawal enabled by defining IRQ_ACK_TIMEOUT_EN.
module irq_service_arbiter #(
    parameter int NUM_IRQ     = 3,
    parameter int ID_W        = $clog2(NUM_IRQ),
    parameter int ACK_TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  rst,
    irq_service_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    if (NUM_IRQ < 2 || ACK_TIMEOUT < 1) begin : g_bad_param
        $error("irq_service_arbiter: NUM_IRQ must be >= 2 and ACK_TIMEOUT >= 1");
    end

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] req_q;
    logic [NUM_IRQ-1:0] req_rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [ID_W-1:0]    base;
    logic [ID_W-1:0]    winner;
    logic               found;
    int                 cand;
    logic               ack_clear;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        if (int'(id) == NUM_IRQ - 1) return '0;
        return id + 1'b1;
    endfunction

    assign req_rise = bus.irq_req & ~req_q;
    assign eligible = pend_q & bus.irq_enable & ~bus.irq_mask;
    assign base     = bus.rr_mode ? rr_ptr_q : '0;

    // Circular search from base; in fixed mode base is 0, so lowest index wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            cand = int'(base) + k;
            if (cand >= NUM_IRQ) cand = cand - NUM_IRQ;
            if (!found && eligible[ID_W'(cand)]) begin
                winner = ID_W'(cand);
                found  = 1'b1;
            end
        end
    end

`ifdef IRQ_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] ack_cnt_q;
    logic             timeout_err_q;
    logic             timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            ack_cnt_q <= (state_q == ASSERT) ? ack_cnt_q + 1'b1 : '0;
            if (timeout_hit) timeout_err_q <= 1'b1;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        rr_ptr_d  = rr_ptr_q;
        ack_clear = 1'b0;
`ifdef IRQ_ACK_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = winner;
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                // Ack beats withdrawal, withdrawal beats timeout.
                if (bus.cpu_ack) begin
                    ack_clear = 1'b1;
                    state_d   = SERVICE;
                end else if (!eligible[id_q]) begin
                    state_d = IDLE;
                end
`ifdef IRQ_ACK_TIMEOUT_EN
                else if (ack_cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                    rr_ptr_d    = next_id(id_q);
                end
`endif
            end
            SERVICE: begin
                if (bus.cpu_eoi) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_id(id_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new event on the acked source in the ack cycle keeps it pending.
    always_comb begin
        pend_d = pend_q;
        if (ack_clear) pend_d[id_q] = 1'b0;
        pend_d = pend_d | (req_rise & bus.irq_enable);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            id_q     <= '0;
            rr_ptr_q <= '0;
            pend_q   <= '0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            pend_q   <= pend_d;
            req_q    <= bus.irq_req;
        end
    end

    assign bus.irq_out    = (state_q == ASSERT);
    assign bus.in_service = (state_q == SERVICE);
    assign bus.irq_id     = id_q;
    assign bus.pending    = pend_q;
endmodule

// File: tb/tb_irq_service_arbiter.sv
// tb/tb_irq_service_arbiter.sv - scoreboard bench for irq_service_arbiter
module tb_irq_service_arbiter;
    localparam int N   = 3;
    localparam int IDW = $clog2(N);
    localparam int TMO = 8;

    typedef struct packed {
        logic           out;
        logic [IDW-1:0] id;
        logic           svc;
        logic [N-1:0]   pend;
        logic           terr;
    } snap_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] en = '1;
    logic [N-1:0] mask = '0;
    logic         rr = 1'b0;
    logic         ack = 1'b0;
    logic         eoi = 1'b0;

    int    total = 0;
    int    bad = 0;
    snap_t exp_q[$];

    // Reference model: what is pending, which source (if any) is on offer or being served.
    bit [N-1:0] m_pend, m_hist;
    bit         m_presenting, m_servicing, m_terr;
    int         m_cur, m_rr, m_wait;

    always #5 clk = ~clk;

    irq_service_arbiter_if #(.NUM_IRQ(N), .ID_W(IDW)) bus ();

    assign bus.irq_req    = req;
    assign bus.irq_enable = en;
    assign bus.irq_mask   = mask;
    assign bus.rr_mode    = rr;
    assign bus.cpu_ack    = ack;
    assign bus.cpu_eoi    = eoi;

    irq_service_arbiter #(.NUM_IRQ(N), .ID_W(IDW), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic int pick(input bit [N-1:0] elig, input int start);
        for (int k = 0; k < N; k++) begin
            if (elig[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge();
        bit [N-1:0] rise, elig, nxt;
        if (rst) begin
            m_pend = '0; m_hist = '0; m_presenting = 0; m_servicing = 0;
            m_terr = 0; m_cur = 0; m_rr = 0; m_wait = 0;
            return;
        end
        rise   = req & ~m_hist;
        elig   = m_pend & en & ~mask;
        nxt    = m_pend;
        m_hist = req;
        if (m_presenting) begin
            if (ack) begin
                nxt[m_cur]   = 1'b0;
                m_presenting = 0;
                m_servicing  = 1;
            end else if (!elig[m_cur]) begin
                m_presenting = 0;
            end else begin
                m_wait++;
`ifdef IRQ_ACK_TIMEOUT_EN
                if (m_wait == TMO) begin
                    m_presenting = 0;
                    m_terr       = 1;
                    m_rr         = (m_cur + 1) % N;
                end
`endif
            end
        end else if (m_servicing) begin
            if (eoi) begin
                m_servicing = 0;
                m_rr        = (m_cur + 1) % N;
            end
        end else if (elig != 0) begin
            m_cur        = pick(elig, rr ? m_rr : 0);
            m_presenting = 1;
            m_wait       = 0;
        end
        m_pend = nxt | (rise & en);
    endtask

    task automatic cycle();
        snap_t e;
        model_edge();
        e = {m_presenting, IDW'(m_cur), m_servicing, m_pend, m_terr};
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic wait_present(input string tag);
        int n;
        n = 0;
        while (!m_presenting && n < 30) begin
            cycle();
            n++;
        end
        if (!m_presenting) begin
            total++;
            bad++;
            $display("FAIL %s: no presentation within 30 cycles", tag);
        end
    endtask

    task automatic serve(input int want_id, input string tag);
        wait_present(tag);
        chk({tag, "_id"}, 32'(bus.irq_id), 32'(want_id));
        chk({tag, "_out"}, 32'(bus.irq_out), 32'd1);
        ack = 1'b1; cycle(); ack = 1'b0;
        cycle();
        eoi = 1'b1; cycle(); eoi = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                snap_t e, a;
                e = exp_q.pop_front();
                a = {bus.irq_out, bus.irq_id, bus.in_service, bus.pending, bus.timeout_err};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL snapshot t=%0t got out=%b id=%0d svc=%b pend=%b terr=%b expected out=%b id=%0d svc=%b pend=%b terr=%b",
                             $time, a.out, a.id, a.svc, a.pend, a.terr, e.out, e.id, e.svc, e.pend, e.terr);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset and single event on source 2
        cycle(); cycle();
        rst = 1'b0;
        repeat (3) cycle();
        chk("reset_pending", 32'(bus.pending), 32'd0);
        chk("reset_out", 32'(bus.irq_out), 32'd0);
        req = 3'b100; cycle();
        chk("t1_pending", 32'(bus.pending), 32'b100);
        chk("t1_out_early", 32'(bus.irq_out), 32'd0);
        req = '0; cycle();
        chk("t1_out", 32'(bus.irq_out), 32'd1);
        chk("t1_id", 32'(bus.irq_id), 32'd2);
        ack = 1'b1; cycle(); ack = 1'b0;
        chk("t1_ack_pending", 32'(bus.pending), 32'd0);
        chk("t1_in_service", 32'(bus.in_service), 32'd1);
        cycle();
        eoi = 1'b1; cycle(); eoi = 1'b0;
        chk("t1_eoi_svc", 32'(bus.in_service), 32'd0);
        chk("t1_eoi_out", 32'(bus.irq_out), 32'd0);

        // Fixed priority, next presentation one cycle after eoi
        req = 3'b110; cycle(); req = '0;
        serve(1, "fp_first");
        cycle();
        chk("fp_next_out", 32'(bus.irq_out), 32'd1);
        chk("fp_next_id", 32'(bus.irq_id), 32'd2);
        serve(2, "fp_second");

        // Round-robin rotation and wrap
        rr = 1'b1;
        req = 3'b111; cycle(); req = '0;
        serve(0, "rr_a");
        serve(1, "rr_b");
        serve(2, "rr_c");
        req = 3'b101; cycle(); req = '0;
        serve(0, "rr_wrap0");
        serve(2, "rr_wrap2");
        rr = 1'b0;

        // Mask withdrawal and re-presentation
        req = 3'b010; cycle(); req = '0;
        wait_present("mask_pre");
        mask = 3'b010; cycle();
        chk("mask_out", 32'(bus.irq_out), 32'd0);
        chk("mask_pend1", 32'(bus.pending[1]), 32'd1);
        mask = '0;
        serve(1, "unmask");

        // Disabled source drops its edge
        en = 3'b110; req = 3'b001; cycle();
        req = '0; en = '1; cycle();
        chk("disabled_drop", 32'(bus.pending[0]), 32'd0);

        // New edge in the ack cycle keeps the source pending
        req = 3'b010; cycle(); req = '0;
        wait_present("same_cycle_pre");
        ack = 1'b1; req = 3'b010; cycle(); ack = 1'b0; req = '0;
        chk("set_wins_pend1", 32'(bus.pending[1]), 32'd1);
        chk("set_wins_svc", 32'(bus.in_service), 32'd1);
        cycle();
        eoi = 1'b1; cycle(); eoi = 1'b0;
        serve(1, "reack");

        // Reset during SERVICE
        req = 3'b110; cycle(); req = '0;
        wait_present("rst_pre");
        ack = 1'b1; cycle(); ack = 1'b0;
        chk("rst_pre_svc", 32'(bus.in_service), 32'd1);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rst_svc", 32'(bus.in_service), 32'd0);
        chk("rst_out", 32'(bus.irq_out), 32'd0);
        chk("rst_id", 32'(bus.irq_id), 32'd0);
        chk("rst_pend", 32'(bus.pending), 32'd0);

        // Long wait without ack
        req = 3'b001; cycle(); req = '0;
        wait_present("tmo_pre");
        repeat (100) cycle();
`ifdef IRQ_ACK_TIMEOUT_EN
        chk("tmo_err", 32'(bus.timeout_err), 32'd1);
        chk("tmo_pend0", 32'(bus.pending[0]), 32'd1);
`else
        chk("hold_out", 32'(bus.irq_out), 32'd1);
        chk("hold_err", 32'(bus.timeout_err), 32'd0);
`endif
        rst = 1'b1; cycle(); rst = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req  = N'($urandom);
            en   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            mask = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 99) == 0) rr = ~rr;
            ack  = ($urandom_range(0, 3) == 0);
            eoi  = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            cycle();
        end
        req = '0; ack = 1'b0; eoi = 1'b0; rst = 1'b0;
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_service_arbiter.md
Name: irq_service_arbiter

Overview:
- Sequences interrupt delivery to the CPU.
- Latches per-source interrupt events into pending bits and arbitrates among eligible sources (fixed priority or round-robin).
- Drives a single irq_out/irq_id pair and tracks the CPU ack / end-of-interrupt handshake, so only one interrupt is in service at a time.
- Sits between the interrupt sources (timer, external lines) and the CPU interface of the interrupt controller top level.

Parameters:
- NUM_IRQ, 3, number of interrupt sources; must be >= 2.
- ID_W, $clog2(NUM_IRQ), width of irq_id.
- ACK_TIMEOUT, 64, cycles in ASSERT without cpu_ack before withdrawal; used only with IRQ_ACK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_req  in  NUM_IRQ  per-source request; rising edge = one event.
- irq_enable  in  NUM_IRQ  1 = source may become pending.
- irq_mask  in  NUM_IRQ  1 = pending source blocked from arbitration.
- rr_mode  in  1  0 = fixed priority (index 0 highest); 1 = round-robin.
- cpu_ack  in  1  one-cycle pulse; CPU accepts the presented irq_id.
- cpu_eoi  in  1  one-cycle pulse; CPU finished servicing.
- irq_out  out  1  interrupt request to CPU.
- irq_id  out  ID_W  index of presented or in-service source.
- in_service  out  1  high from accepted ack until eoi.
- pending  out  NUM_IRQ  registered pending bits.
- timeout_err  out  1  sticky ack-timeout flag.

Behaviour:
- Reset:
  - state=IDLE; irq_out=0, irq_id=0, in_service=0, pending=0, timeout_err=0.
  - rr_ptr=0; edge-detect history=0.
  - Reset mid-handshake aborts everything; the next cycle is IDLE.
- Event capture:
  - req_rise[i] = irq_req[i] & ~irq_req_q[i].
  - If req_rise[i] & irq_enable[i]: pending[i] <= 1.
  - If the source is disabled at its edge, the event is dropped.
  - Already pending: no effect (events not counted).
- Clear: pending[irq_id] <= 0 on an accepted cpu_ack. If a new event for the same source arrives in that same cycle, set wins and pending stays 1.
- eligible = pending & irq_enable & ~irq_mask.
- Arbitration (combinational on eligible):
  - Fixed priority: lowest eligible index wins.
  - Round-robin: first eligible index searching upward from rr_ptr, wrapping modulo NUM_IRQ.
- FSM states: IDLE, ASSERT, SERVICE.
- IDLE:
  - If eligible != 0: latch the winner into irq_id, set irq_out=1, go to ASSERT.
  - Else stay.
- ASSERT:
  - irq_out=1 and irq_id stable.
  - On cpu_ack: clear pending[irq_id], irq_out=0, in_service=1, go to SERVICE.
  - If eligible[irq_id] drops (masked/disabled) before ack: irq_out=0, go to IDLE, pending kept. Ack takes precedence in the same cycle.
- SERVICE:
  - irq_out=0, irq_id held.
  - On cpu_eoi: in_service=0, rr_ptr <= (irq_id+1) mod NUM_IRQ, go to IDLE.
- Ignored inputs:
  - cpu_ack outside ASSERT.
  - cpu_eoi outside SERVICE.
  - cpu_ack and cpu_eoi together in ASSERT: treated as ack only.
- Latency:
  - req edge sampled at edge t → pending high after t → irq_out high after t+1.
  - eoi at edge t → next irq_out no earlier than after t+1 (IDLE for one cycle).
- Priority is evaluated only in IDLE. A higher-priority event during ASSERT or SERVICE does not preempt.

Optional Feature:
- Macro: IRQ_ACK_TIMEOUT_EN.
- Defined:
  - Counter cleared on ASSERT entry, increments each ASSERT cycle.
  - If it reaches ACK_TIMEOUT with no ack: irq_out=0, go to IDLE, pending[irq_id] kept.
  - Set timeout_err=1 (sticky until rst).
  - rr_ptr <= (irq_id+1) mod NUM_IRQ, so other sources get a turn in round-robin mode.
- Not defined: no counter; timeout_err tied 0; ASSERT waits indefinitely for cpu_ack.

Test Plan:
1. Reset, enable=3'b111, mask=0, rr_mode=0, pulse irq_req[2] at cycle 5 → pending=3'b100 after edge 5, irq_out=1/irq_id=2 after edge 6; cpu_ack → pending=0, in_service=1; cpu_eoi → in_service=0, state IDLE.
2. Fixed priority: pulse irq_req[1] and irq_req[2] together → irq_id=1 first; after ack+eoi, irq_id=2 presented one cycle after eoi.
3. Round-robin: rr_mode=1, all three pending, three ack/eoi rounds → ids 0,1,2. Re-pend 0 and 2 → id 2 is not presented before 0 only because rr_ptr wrapped to 0, so order is 0 then 2.
4. Mask withdrawal: id 1 presented, set irq_mask[1]=1 before ack → irq_out=0 next cycle, pending[1] still 1; clear mask → id 1 re-presented.
5. Edge cases: irq_enable[0]=0 while irq_req[0] rises → pending[0] stays 0. New irq_req[1] edge in the same cycle as ack of id 1 → pending[1]=1 afterwards. rst asserted in SERVICE → all outputs 0 next cycle.
6. With IRQ_ACK_TIMEOUT_EN and ACK_TIMEOUT=8: present id 0, no ack → irq_out falls after 8 ASSERT cycles, timeout_err=1, pending[0]=1. Without the macro: irq_out held for 100 cycles, timeout_err=0.
